// File: rtl/debounce_edge_if.sv
// debounce_edge_if: raw input level and conditioned outputs of the debouncer
interface debounce_edge_if;
  logic       signal;
  logic       q;
  logic       rise;
  logic       fall;
  logic       busy;
  logic [7:0] glitch_cnt;
  modport master (output signal, input q, rise, fall, busy, glitch_cnt);
  modport slave  (input signal, output q, rise, fall, busy, glitch_cnt);
endinterface

// File: rtl/debounce_edge.sv
// debounce_edge: synchronises a raw level, rejects glitches shorter than STABLE_CYCLES
// and emits a clean level with one-cycle rise/fall strobes
module debounce_edge #(
  parameter int   CNT_W         = 16,
  parameter int   STABLE_CYCLES = 50000,
  parameter logic RESET_LEVEL   = 1'b0
) (
  input logic              clk,
  input logic              reset,
  debounce_edge_if.slave   bus
);
  typedef enum logic {STABLE, SETTLING} state_t;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CYCLES - 1);
  state_t           state_q, state_d;
  logic             s1_q, s_q, q_q, q_d, rise_q, rise_d, fall_q, fall_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       gcnt_q, gcnt_d;
  logic             diff, done, settle_ok, glitch;
  assign diff = s_q != q_q;
  assign done = cnt_q == LAST;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= STABLE;
    else        state_q <= state_d;
  end
  always_comb begin
    state_d = state_q == STABLE ? (diff ? SETTLING : STABLE)
                                : (!diff || done ? STABLE : SETTLING);
  end
  always_comb begin
    settle_ok = state_q == SETTLING && diff && done;
    glitch    = state_q == SETTLING && !diff;
    cnt_d     = state_q == STABLE ? (diff ? CNT_W'(1) : '0)
                                  : (diff && !done ? cnt_q + 1'b1 : '0);
    q_d       = settle_ok ? s_q : q_q;
    rise_d    = settle_ok && s_q;
    fall_d    = settle_ok && !s_q;
    // Saturate so a noisy contact never makes the count wrap back to small values
    gcnt_d    = glitch && gcnt_q != 8'hff ? gcnt_q + 8'd1 : gcnt_q;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_q   <= RESET_LEVEL;
      s_q    <= RESET_LEVEL;
      q_q    <= RESET_LEVEL;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      cnt_q  <= '0;
      gcnt_q <= '0;
    end else begin
      s1_q   <= bus.signal;
      s_q    <= s1_q;
      q_q    <= q_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
      cnt_q  <= cnt_d;
      gcnt_q <= gcnt_d;
    end
  end
  assign bus.q          = q_q;
  assign bus.rise       = rise_q;
  assign bus.fall       = fall_q;
  assign bus.busy       = state_q == SETTLING;
  assign bus.glitch_cnt = gcnt_q;
endmodule

// File: tb/tb_debounce_edge.sv
// tb_debounce_edge: directed stimulus against a run-length model of the debouncer
module tb_debounce_edge;
  localparam int N = 4;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int checks = 0;
  int failures = 0;
  debounce_edge_if bus ();
  debounce_edge #(.CNT_W(16), .STABLE_CYCLES(N), .RESET_LEVEL(1'b0)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );
  always #5 clk = ~clk;

  logic m_p1, m_p2, m_q, m_rise, m_fall;
  int   m_run, m_g;
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_p1 <= 0; m_p2 <= 0; m_q <= 0; m_rise <= 0; m_fall <= 0; m_run <= 0; m_g <= 0;
    end else begin
      m_p1 <= bus.signal;
      m_p2 <= m_p1;
      m_rise <= 0;
      m_fall <= 0;
      if (m_p2 != m_q) begin
        if (m_run + 1 == N) begin
          m_q <= m_p2; m_rise <= m_p2; m_fall <= !m_p2; m_run <= 0;
        end else m_run <= m_run + 1;
      end else begin
        if (m_run > 0 && m_g < 255) m_g <= m_g + 1;
        m_run <= 0;
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("model_q", bus.q, m_q);
    chk("model_rise", bus.rise, m_rise);
    chk("model_fall", bus.fall, m_fall);
    chk("model_busy", bus.busy, m_run > 0);
    chk("model_glitch_cnt", bus.glitch_cnt, m_g);
    if (bus.rise && bus.fall) chk("rise_fall_exclusive", 1, 0);
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    bus.signal = 0;
    step(3);
    chk("reset_q", bus.q, 0);
    chk("reset_busy", bus.busy, 0);
    chk("reset_gc", bus.glitch_cnt, 0);
    #2 reset = 1;
    step(20);
    chk("idle_q", bus.q, 0);
    chk("idle_rise", bus.rise, 0);
    chk("idle_busy", bus.busy, 0);
    bus.signal = 1;
    step(3);
    chk("rise_busy_k2", bus.busy, 1);
    step(2);
    chk("rise_q_k4", bus.q, 0);
    step(1);
    chk("rise_q_k5", bus.q, 1);
    chk("rise_strobe_k5", bus.rise, 1);
    step(1);
    chk("rise_strobe_k6", bus.rise, 0);
    chk("rise_busy_k6", bus.busy, 0);
    step(3);
    bus.signal = 0;
    step(5);
    chk("fall_q_k4", bus.q, 1);
    step(1);
    chk("fall_strobe_k5", bus.fall, 1);
    chk("fall_q_k5", bus.q, 0);
    step(1);
    chk("fall_strobe_k6", bus.fall, 0);
    step(3);
    bus.signal = 1;
    step(3);
    bus.signal = 0;
    step(8);
    chk("late_glitch_q", bus.q, 0);
    chk("late_glitch_gc", bus.glitch_cnt, 1);
    for (int i = 0; i < 300; i++) begin
      bus.signal = 1;
      step(2);
      bus.signal = 0;
      step(6);
      if (i == 0) chk("pulse_gc_first", bus.glitch_cnt, 2);
    end
    chk("pulse_gc_sat", bus.glitch_cnt, 255);
    chk("pulse_q", bus.q, 0);
    bus.signal = 1;
    step(3);
    chk("abort_busy", bus.busy, 1);
    #2 reset = 0;
    #1;
    chk("abort_q", bus.q, 0);
    chk("abort_busy_clr", bus.busy, 0);
    chk("abort_gc_clr", bus.glitch_cnt, 0);
    step(1);
    #2 reset = 1;
    step(5);
    chk("post_reset_q_k4", bus.q, 0);
    step(1);
    chk("post_reset_q_k5", bus.q, 1);
    chk("post_reset_rise", bus.rise, 1);
    step(3);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
